multicycle_control: RTL and testbench
=====================================

# multicycle_control

Multi-cycle main control FSM for the MIPS datapath, the sequential successor to the single-cycle opcode decoder. It sequences each instruction through fetch, decode, execute, memory and write-back states and issues the per-state datapath strobes. It supports a parametrised memory ready/wait handshake, JR detection, illegal-opcode trapping and a retired-instruction counter. It sits between the instruction register (opcode/funct) and the shared-memory multi-cycle datapath.

## Interface
- MEM_HANDSHAKE, 1, 1 = memory states wait for mem_ready; 0 = mem_ready ignored (treated as 1)
- ILLEGAL_TRAP, 1, 1 = unknown opcode enters TRAP; 0 = unknown opcode retires as NOP
- CNT_W, 32, width of retired counter
- clk  in  1  clock, all state changes on rising edge
- rst_n  in  1  asynchronous, active-low reset
- opcode  in  6  IR[31:26]; sampled only in DECODE
- funct  in  6  IR[5:0]; sampled only in DECODE
- mem_ready  in  1  memory access completes this cycle
- pc_write, pc_write_cond, branch_ne, i_or_d, mem_read, mem_write, ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, jal  out  1 each  datapath strobes
- alu_src_b  out  2  00 reg B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
- alu_op  out  2  00 add, 01 sub/compare, 10 funct-decoded
- pc_source  out  2  00 ALU result, 01 ALUOut (branch target), 10 jump target, 11 rs (JR)
- illegal_op  out  1  high in TRAP
- state  out  4  current state code (debug)
- retired  out  CNT_W  instructions completed, wraps modulo 2^CNT_W

## Operation
- Outputs are decoded from the current state combinationally. Any strobe not listed for a state is 0.
- Opcode and funct are latched at the end of DECODE; later states use only the latched copies.
- FETCH (0): mem_read, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00. ir_write and pc_write are asserted only in the cycle mem_ready=1. The FSM stays in FETCH until then, then goes to DECODE.
- DECODE (1): alu_src_a=0, alu_src_b=11, alu_op=00. Next state by opcode:
  - 100011 / 101011 → MEMADDR
  - 000000 with funct 001000 → JR; other 000000 → EXEC
  - 000100 / 000101 → BRANCH
  - 001000 → ADDI_EX
  - 000010 / 000011 → JUMP
  - other opcodes → TRAP (ILLEGAL_TRAP=1) or FETCH (ILLEGAL_TRAP=0)
- MEMADDR (2): alu_src_a=1, alu_src_b=10, alu_op=00. LW → MEMRD, SW → MEMWR.
- MEMRD (3): mem_read, i_or_d=1. Waits for mem_ready, then MEMWB.
- MEMWB (4): reg_write, mem_to_reg=1, reg_dst=0. Then FETCH.
- MEMWR (5): mem_write, i_or_d=1. Waits for mem_ready, then FETCH.
- EXEC (6): alu_src_a=1, alu_src_b=00, alu_op=10. Then RWB.
- RWB (7): reg_write, reg_dst=1. Then FETCH.
- BRANCH (8): alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond, pc_source=01, branch_ne=(opcode==000101). Then FETCH.
- JUMP (9): pc_write, pc_source=10. For JAL, jal=1 and reg_write=1 (datapath writes PC+4 to $31). Then FETCH.
- ADDI_EX (10): alu_src_a=1, alu_src_b=10, alu_op=00. Then ADDI_WB.
- ADDI_WB (11): reg_write, reg_dst=0, mem_to_reg=0. Then FETCH.
- JR (12): pc_write, pc_source=11, reg_write=0. Then FETCH.
- TRAP (15): illegal_op=1, all other strobes 0. Left only by reset.
- retired increments by 1 on every transition into FETCH, including an ILLEGAL_TRAP=0 NOP. It never increments on entry to TRAP or while stalled.

## Timing
- While rst_n=0: state=FETCH, retired=0, latched opcode/funct=0, and every output is forced 0 (including mem_read and state readout 0). The first fetch is driven in the first cycle after rst_n rises.
- Reset asserted mid-instruction aborts it immediately: no further strobes, and retired does not count the aborted instruction.
- Cycles with mem_ready=1 always: BEQ/BNE/J/JAL/JR 3, R-type/SW/ADDI 4, LW 5.
- Each low mem_ready cycle in FETCH, MEMRD or MEMWR adds one cycle. All strobes of that state stay held, but ir_write and pc_write stay low until the completing cycle.
- With MEM_HANDSHAKE=0, FETCH, MEMRD and MEMWR each last exactly one cycle regardless of mem_ready.
- Opcode/funct changes after DECODE have no effect on the current instruction.

## Test plan
- Reset, then opcode=000000, funct=100000, mem_ready=1: state sequence 0,1,6,7,0. reg_dst=reg_write=1 only in RWB. retired=1 after 4 cycles.
- LW with mem_ready low for 2 cycles in FETCH and 1 in MEMRD: 8 cycles total. ir_write is a single pulse in the completing FETCH cycle. mem_to_reg=reg_write=1 in state 4.
- BNE (000101): state 8 drives pc_write_cond=1, branch_ne=1, pc_source=01, alu_op=01. BEQ drives the same with branch_ne=0.
- JAL (000011): state 9 drives jal=1, reg_write=1, pc_write=1, pc_source=10. JR (funct 001000) reaches state 12 with pc_source=11 and reg_write=0.
- Opcode 111111: with ILLEGAL_TRAP=1, TRAP is held with illegal_op=1 and retired frozen until rst_n pulse. With ILLEGAL_TRAP=0, returns to FETCH after DECODE and retired increments.
- CNT_W=4, 16 consecutive J instructions: retired wraps from 15 to 0. Asserting rst_n=0 mid-MEMWR zeroes all outputs in the same cycle.

Source files
------------

// File: rtl/multicycle_control.sv
// multicycle_control: multi-cycle MIPS main control FSM with memory handshake, JR, trap and retire counter
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   opcode, funct     instruction register fields, sampled in DECODE
//   mem_ready         memory access completes this cycle
//   pc_write .. jal   single-bit datapath strobes
//   alu_src_b, alu_op, pc_source  two-bit datapath selects
//   illegal_op        high while trapped on an unknown opcode
//   state             current state code (debug)
//   retired           count of completed instructions, wraps
module multicycle_control #(
    parameter bit MEM_HANDSHAKE = 1'b1,
    parameter bit ILLEGAL_TRAP = 1'b1,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             branch_ne,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             mem_to_reg,
    output logic             reg_dst,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic             jal,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       pc_source,
    output logic             illegal_op,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] retired
);
    localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADDR = 4'd2, S_MEMRD = 4'd3,
                           S_MEMWB = 4'd4, S_MEMWR = 4'd5, S_EXEC = 4'd6, S_RWB = 4'd7,
                           S_BRANCH = 4'd8, S_JUMP = 4'd9, S_ADDI_EX = 4'd10, S_ADDI_WB = 4'd11,
                           S_JR = 4'd12, S_TRAP = 4'd15;
    localparam logic [5:0] OP_RTYPE = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                           OP_BEQ = 6'b000100, OP_BNE = 6'b000101, OP_ADDI = 6'b001000,
                           OP_J = 6'b000010, OP_JAL = 6'b000011, FN_JR = 6'b001000;
    logic [3:0] st, nx;
    logic [5:0] op_q;
    logic       rdy;
    assign rdy = !MEM_HANDSHAKE || mem_ready;
    assign state = rst_n ? st : 4'd0;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) st <= S_FETCH;
        else st <= nx;
    end
    // Later states see only the opcode captured while in DECODE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q <= 6'd0;
            retired <= '0;
        end else begin
            if (st == S_DECODE) op_q <= opcode;
            if (nx == S_FETCH && st != S_FETCH) retired <= retired + 1'b1;
        end
    end
    always_comb begin
        nx = S_FETCH;
        case (st)
            S_FETCH:   nx = rdy ? S_DECODE : S_FETCH;
            S_DECODE:  nx = (opcode == OP_LW || opcode == OP_SW) ? S_MEMADDR :
                            (opcode == OP_RTYPE) ? (funct == FN_JR ? S_JR : S_EXEC) :
                            (opcode == OP_BEQ || opcode == OP_BNE) ? S_BRANCH :
                            (opcode == OP_ADDI) ? S_ADDI_EX :
                            (opcode == OP_J || opcode == OP_JAL) ? S_JUMP :
                            ILLEGAL_TRAP ? S_TRAP : S_FETCH;
            S_MEMADDR: nx = (op_q == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   nx = rdy ? S_MEMWB : S_MEMRD;
            S_MEMWR:   nx = rdy ? S_FETCH : S_MEMWR;
            S_EXEC:    nx = S_RWB;
            S_ADDI_EX: nx = S_ADDI_WB;
            S_TRAP:    nx = S_TRAP;
            default:   nx = S_FETCH;
        endcase
    end
    always_comb begin
        {pc_write, pc_write_cond, branch_ne, i_or_d, mem_read, mem_write, ir_write,
         mem_to_reg, reg_dst, reg_write, alu_src_a, jal, illegal_op} = '0;
        alu_src_b = 2'b00;
        alu_op = 2'b00;
        pc_source = 2'b00;
        if (rst_n) begin
            case (st)
                S_FETCH: begin
                    mem_read = 1'b1;
                    alu_src_b = 2'b01;
                    ir_write = rdy;
                    pc_write = rdy;
                end
                S_DECODE:  alu_src_b = 2'b11;
                S_MEMADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                S_MEMRD: begin
                    mem_read = 1'b1;
                    i_or_d = 1'b1;
                end
                S_MEMWB: begin
                    reg_write = 1'b1;
                    mem_to_reg = 1'b1;
                end
                S_MEMWR: begin
                    mem_write = 1'b1;
                    i_or_d = 1'b1;
                end
                S_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_op = 2'b10;
                end
                S_RWB: begin
                    reg_write = 1'b1;
                    reg_dst = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a = 1'b1;
                    alu_op = 2'b01;
                    pc_write_cond = 1'b1;
                    pc_source = 2'b01;
                    branch_ne = (op_q == OP_BNE);
                end
                S_JUMP: begin
                    pc_write = 1'b1;
                    pc_source = 2'b10;
                    jal = (op_q == OP_JAL);
                    reg_write = (op_q == OP_JAL);
                end
                S_ADDI_EX: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                S_ADDI_WB: reg_write = 1'b1;
                S_JR: begin
                    pc_write = 1'b1;
                    pc_source = 2'b11;
                end
                S_TRAP:    illegal_op = 1'b1;
                default:   ;
            endcase
        end
    end
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: random-stimulus check of two multicycle_control builds against an instruction-level model
module tb_multicycle_control;
    logic clk = 1'b0, rst_n = 1'b0, mem_ready = 1'b1;
    logic [5:0] opcode = 6'd0, funct = 6'd0;
    always #5 clk = ~clk;

    logic a_pw, a_pwc, a_bne, a_iord, a_mr, a_mw, a_irw, a_m2r, a_rdst, a_rw, a_asa, a_jal, a_ill;
    logic [1:0] a_asb, a_aop, a_pcs;
    logic [3:0] a_st;
    logic [31:0] a_ret;
    logic b_pw, b_pwc, b_bne, b_iord, b_mr, b_mw, b_irw, b_m2r, b_rdst, b_rw, b_asa, b_jal, b_ill;
    logic [1:0] b_asb, b_aop, b_pcs;
    logic [3:0] b_st;
    logic [3:0] b_ret;

    multicycle_control u_a (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
        .pc_write(a_pw), .pc_write_cond(a_pwc), .branch_ne(a_bne), .i_or_d(a_iord),
        .mem_read(a_mr), .mem_write(a_mw), .ir_write(a_irw), .mem_to_reg(a_m2r),
        .reg_dst(a_rdst), .reg_write(a_rw), .alu_src_a(a_asa), .jal(a_jal),
        .alu_src_b(a_asb), .alu_op(a_aop), .pc_source(a_pcs), .illegal_op(a_ill),
        .state(a_st), .retired(a_ret)
    );
    multicycle_control #(.MEM_HANDSHAKE(1'b0), .ILLEGAL_TRAP(1'b0), .CNT_W(4)) u_b (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
        .pc_write(b_pw), .pc_write_cond(b_pwc), .branch_ne(b_bne), .i_or_d(b_iord),
        .mem_read(b_mr), .mem_write(b_mw), .ir_write(b_irw), .mem_to_reg(b_m2r),
        .reg_dst(b_rdst), .reg_write(b_rw), .alu_src_a(b_asa), .jal(b_jal),
        .alu_src_b(b_asb), .alu_op(b_aop), .pc_source(b_pcs), .illegal_op(b_ill),
        .state(b_st), .retired(b_ret)
    );

    logic [22:0] a_vec, b_vec;
    assign a_vec = {a_pw, a_pwc, a_bne, a_iord, a_mr, a_mw, a_irw, a_m2r, a_rdst, a_rw, a_asa, a_jal,
                    a_asb, a_aop, a_pcs, a_ill, a_st};
    assign b_vec = {b_pw, b_pwc, b_bne, b_iord, b_mr, b_mw, b_irw, b_m2r, b_rdst, b_rw, b_asa, b_jal,
                    b_asb, b_aop, b_pcs, b_ill, b_st};

    int n_checks = 0, n_errors = 0;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Instruction-level model: DECODE expands the opcode into the list of states still to visit.
    bit hs [2] = '{1'b1, 1'b0};
    bit trap [2] = '{1'b1, 1'b0};
    int st [2];
    logic [5:0] opl [2];
    logic [31:0] ret [2];
    int plan [2][3];
    int pn [2], pi [2];

    function automatic logic [22:0] exp_vec(int s, logic [5:0] op, logic rdy, logic rn);
        logic f, pw, pwc, bne, iord, mr, mw, irw, m2r, rdst, rw, asa, jl, ill;
        logic [1:0] asb, aop, pcs;
        if (!rn) return 23'd0;
        f = (s == 0);
        pw = (f && rdy) || s == 9 || s == 12;
        pwc = (s == 8);
        bne = (s == 8) && op == 6'd5;
        iord = (s == 3) || (s == 5);
        mr = f || s == 3;
        mw = (s == 5);
        irw = f && rdy;
        m2r = (s == 4);
        rdst = (s == 7);
        jl = (s == 9) && op == 6'd3;
        rw = s == 4 || s == 7 || s == 11 || jl;
        asa = s == 2 || s == 6 || s == 8 || s == 10;
        asb = f ? 2'd1 : s == 1 ? 2'd3 : (s == 2 || s == 10) ? 2'd2 : 2'd0;
        aop = s == 8 ? 2'd1 : s == 6 ? 2'd2 : 2'd0;
        pcs = s == 8 ? 2'd1 : s == 9 ? 2'd2 : s == 12 ? 2'd3 : 2'd0;
        ill = (s == 15);
        return {pw, pwc, bne, iord, mr, mw, irw, m2r, rdst, rw, asa, jl, asb, aop, pcs, ill, 4'(s)};
    endfunction

    task automatic set_plan(input int i, input int n, input int p0, input int p1, input int p2);
        pn[i] = n;
        pi[i] = 0;
        plan[i][0] = p0;
        plan[i][1] = p1;
        plan[i][2] = p2;
    endtask

    task automatic step(input int i);
        logic rdy;
        rdy = !hs[i] || mem_ready;
        if (!rst_n) begin
            st[i] = 0;
            ret[i] = 0;
            opl[i] = 0;
            pn[i] = 0;
            pi[i] = 0;
        end else if (st[i] == 0) begin
            if (rdy) st[i] = 1;
        end else if (st[i] == 15) begin
            st[i] = 15;
        end else if ((st[i] == 3 || st[i] == 5) && !rdy) begin
            st[i] = st[i];
        end else begin
            if (st[i] == 1) begin
                opl[i] = opcode;
                case (opcode)
                    6'd35:      set_plan(i, 3, 2, 3, 4);
                    6'd43:      set_plan(i, 2, 2, 5, 0);
                    6'd0:       if (funct == 6'd8) set_plan(i, 1, 12, 0, 0); else set_plan(i, 2, 6, 7, 0);
                    6'd4, 6'd5: set_plan(i, 1, 8, 0, 0);
                    6'd8:       set_plan(i, 2, 10, 11, 0);
                    6'd2, 6'd3: set_plan(i, 1, 9, 0, 0);
                    default:    if (trap[i]) set_plan(i, 1, 15, 0, 0); else set_plan(i, 0, 0, 0, 0);
                endcase
            end
            if (pi[i] < pn[i]) begin
                st[i] = plan[i][pi[i]];
                pi[i]++;
            end else begin
                st[i] = 0;
                ret[i] = ret[i] + 1;
            end
        end
    endtask

    logic [5:0] ops [11] = '{6'd0, 6'd0, 6'd35, 6'd43, 6'd4, 6'd5, 6'd8, 6'd2, 6'd3, 6'd63, 6'd0};
    bit did_rst = 0;

    initial begin
        for (int i = 0; i < 2; i++) begin
            st[i] = 0; ret[i] = 0; opl[i] = 0; pn[i] = 0; pi[i] = 0;
        end
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (c < 3) begin
                rst_n = 1'b0;
            end else if (c < 70) begin
                rst_n = 1'b1;
                opcode = 6'd2;
                mem_ready = 1'b1;
            end else if (c < 100) begin
                opcode = (c < 72) ? 6'd43 : 6'($urandom_range(0, 63));
                mem_ready = ($urandom_range(0, 2) != 0);
                if (st[0] == 5 && !did_rst) begin
                    rst_n = 1'b0;
                    did_rst = 1;
                end else begin
                    rst_n = 1'b1;
                end
            end else begin
                rst_n = ($urandom_range(0, 99) != 0);
                opcode = ops[$urandom_range(0, 10)];
                if (opcode == 6'd0 && $urandom_range(0, 3) == 0) opcode = 6'($urandom_range(0, 63));
                funct = ($urandom_range(0, 3) == 0) ? 6'd8 : 6'($urandom_range(0, 63));
                mem_ready = ($urandom_range(0, 3) != 0);
            end
            #1;
            check("a_outputs", {9'd0, a_vec}, {9'd0, exp_vec(st[0], opl[0], mem_ready, rst_n)});
            check("a_retired", a_ret, rst_n ? ret[0] : 32'd0);
            check("b_outputs", {9'd0, b_vec}, {9'd0, exp_vec(st[1], opl[1], 1'b1, rst_n)});
            check("b_retired", {28'd0, b_ret}, rst_n ? (ret[1] & 32'hF) : 32'd0);
            step(0);
            step(1);
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
